// File: rtl/logbuf_ctrl_pkg.sv
// logbuf_ctrl_pkg: shared state encodings, record sizes and index-field layout for the logbuf controller
package logbuf_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, RDIX, SELIX, WRDAT, ADVIX, DONE} state_t;
  localparam int PAYLOAD_BYTES = 4;
  localparam int LOG_REC_BYTES = 5;
  localparam int IX_W = 8;
  localparam int GET_LSB = 0;
  localparam int PUT_LSB = 8;
  function automatic logic [IX_W-1:0] ix_inc(input logic [IX_W-1:0] ix, input int n);
    return (int'(ix) + 1 == n) ? '0 : ix + 1'b1;
  endfunction
endpackage

// File: rtl/logbuf_ctrl_rr_arb.sv
// rr_arb: round-robin winner search starting at ptr, wrapping to the lowest set request
module rr_arb #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] win,
  output logic          vld
);
  // second pass overrides with the lowest request at or above ptr when one exists
  always_comb begin
    win = '0;
    for (int j = N - 1; j >= 0; j--) if (req[j]) win = IW'(j);
    for (int j = N - 1; j >= 0; j--) if (req[j] && j >= int'(ptr)) win = IW'(j);
  end
  assign vld = |req;
endmodule

// File: rtl/logbuf_ctrl.sv
// logbuf_ctrl: serialises hardware log records into the logbuf and shares its port with the CPU
module logbuf_ctrl
  import logbuf_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int NUM_ENTRIES = 32,
  parameter logic [7:0] SRC_BASE = 8'h10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [32*NUM_REQ-1:0] payload,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic                 cpu_stb,
  input  logic                 cpu_we,
  input  logic                 cpu_addr,
  input  logic [15:0]          cpu_din,
  output logic [31:0]          cpu_dout,
  output logic                 cpu_ack,
  input  logic                 cpu_lock,
  output logic                 lb_stb,
  output logic                 lb_we,
  output logic                 lb_addr,
  output logic [15:0]          lb_dout,
  input  logic [31:0]          lb_din,
  input  logic                 lb_ack
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state;
  logic [IW-1:0] rr_ptr, win, arb_win;
  logic arb_vld, pass;
  logic [2:0] cnt;
  logic [8*PAYLOAD_BYTES-1:0] pay;
  logic [IX_W-1:0] put, get, np, ng;
  logic fsm_stb, fsm_we, fsm_addr;
  logic [15:0] fsm_dout;
  rr_arb #(.N(NUM_REQ)) u_arb (.req(req), .ptr(rr_ptr), .win(arb_win), .vld(arb_vld));
  assign np = ix_inc(put, NUM_ENTRIES);
  assign ng = (np == get) ? ix_inc(get, NUM_ENTRIES) : get;
  // FSM-driven lb_* registers are all zero in IDLE, so the CPU path only needs OR-ing in
  assign pass = (state == IDLE) && cpu_stb;
  assign lb_stb = pass | fsm_stb;
  assign lb_we = pass ? cpu_we : fsm_we;
  assign lb_addr = pass ? cpu_addr : fsm_addr;
  assign lb_dout = pass ? cpu_din : fsm_dout;
  assign cpu_dout = pass ? lb_din : '0;
  assign cpu_ack = pass & lb_ack;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      req_ack <= '0;
      win <= '0;
      pay <= '0;
      put <= '0;
      get <= '0;
      fsm_stb <= 1'b0;
      fsm_we <= 1'b0;
      fsm_addr <= 1'b0;
      fsm_dout <= '0;
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: if (!cpu_stb && !cpu_lock && arb_vld) begin
          state <= RDIX;
          win <= arb_win;
          pay <= payload[32*arb_win +: 32];
          rr_ptr <= (arb_win == IW'(NUM_REQ - 1)) ? '0 : arb_win + 1'b1;
          fsm_stb <= 1'b1;
          fsm_we <= 1'b0;
          fsm_addr <= 1'b1;
          fsm_dout <= '0;
        end
        RDIX: begin
          state <= SELIX;
          put <= lb_din[PUT_LSB +: IX_W];
          get <= lb_din[GET_LSB +: IX_W];
          fsm_we <= 1'b1;
          fsm_dout <= {lb_din[PUT_LSB +: IX_W], lb_din[GET_LSB +: IX_W]};
        end
        SELIX: begin
          state <= WRDAT;
          cnt <= '0;
          fsm_addr <= 1'b0;
          fsm_dout <= {8'h00, SRC_BASE + 8'(win)};
        end
        WRDAT: if (cnt == 3'(LOG_REC_BYTES - 1)) begin
          state <= ADVIX;
          cnt <= '0;
          fsm_addr <= 1'b1;
          fsm_dout <= {np, ng};
        end else begin
          cnt <= cnt + 1'b1;
          fsm_dout <= {8'h00, pay[8*cnt +: 8]};
        end
        ADVIX: begin
          state <= DONE;
          req_ack[win] <= 1'b1;
          fsm_stb <= 1'b0;
          fsm_we <= 1'b0;
          fsm_addr <= 1'b0;
          fsm_dout <= '0;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
